ro_puf_challenge_ctrl: RTL and testbench

- Drives the ring-oscillator PUF array for one challenge: decodes a challenge pair into the 128-bit oscillator enable bus and steers the two 128:1 selection muxes.
- Counts rising edges on the two selected oscillator outputs over a fixed window, then emits a 1-bit response.
- Sits between the challenge source (host/test logic) and the oscillator array plus its pair of output muxes. It is the selection-generating, output-consuming end of the mux interface.

---
 rtl/ro_puf_challenge_ctrl.sv | 146 ++++++++++++++
 tb/tb_ro_puf_challenge_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_puf_challenge_ctrl.sv
// Ring-oscillator PUF challenge controller: decodes a challenge pair into
// oscillator enables and mux selects, counts rising edges on the two selected
// oscillators over a fixed window, and reports which one was faster.
module ro_puf_challenge_ctrl #(
  parameter int N_RO   = 128,
  parameter int SEL_W  = 8,
  parameter int CNT_W  = 16,
  parameter int SETTLE = 8,
  parameter int WINDOW = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SEL_W-1:0]  sel_a,
  input  logic [SEL_W-1:0]  sel_b,
  output logic [N_RO-1:0]   ro_en,
  output logic [SEL_W-1:0]  mux_sel_a,
  output logic [SEL_W-1:0]  mux_sel_b,
  input  logic              ro_a,
  input  logic              ro_b,
  output logic              busy,
  output logic              done,
  output logic              response,
  output logic              error,
  output logic [CNT_W-1:0]  count_a,
  output logic [CNT_W-1:0]  count_b
);

  localparam int TW = $clog2((WINDOW > SETTLE) ? WINDOW : SETTLE) + 1;
  localparam logic [TW-1:0]   SETTLE_LAST = TW'(SETTLE - 1);
  localparam logic [TW-1:0]   WINDOW_LAST = TW'(WINDOW - 1);
  localparam logic [N_RO-1:0] ONE_HOT0    = N_RO'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_COUNT,
    ST_RESULT
  } state_t;

  state_t           state;
  logic [TW-1:0]    timer;
  logic [2:0]       sync_a;
  logic [2:0]       sync_b;
  logic [CNT_W-1:0] edges_a;
  logic [CNT_W-1:0] edges_b;
  logic [CNT_W-1:0] next_a;
  logic [CNT_W-1:0] next_b;
  logic             rise_a;
  logic             rise_b;
  logic             invalid;

  // Two-flop synchronizers plus a history flop; free-running in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= {sync_a[1:0], ro_a};
      sync_b <= {sync_b[1:0], ro_b};
    end
  end

  // Rising-edge detect, saturating counter update and challenge validity.
  always_comb begin
    rise_a  = sync_a[1] & ~sync_a[2];
    rise_b  = sync_b[1] & ~sync_b[2];
    next_a  = edges_a;
    next_b  = edges_b;
    if (state == ST_COUNT && rise_a && edges_a != '1) next_a = edges_a + CNT_W'(1);
    if (state == ST_COUNT && rise_b && edges_b != '1) next_b = edges_b + CNT_W'(1);
    invalid = sel_a[SEL_W-1] | sel_b[SEL_W-1] | (sel_a == sel_b);
  end

  // Challenge FSM with registered outputs. The final-window result is taken
  // from the next-count values so the last COUNT cycle's edge is included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      timer     <= '0;
      edges_a   <= '0;
      edges_b   <= '0;
      ro_en     <= '0;
      mux_sel_a <= '0;
      mux_sel_b <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      response  <= 1'b0;
      error     <= 1'b0;
      count_a   <= '0;
      count_b   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            mux_sel_a <= sel_a;
            mux_sel_b <= sel_b;
            count_a   <= '0;
            count_b   <= '0;
            response  <= 1'b0;
            if (invalid) begin
              error <= 1'b1;
              done  <= 1'b1;
              state <= ST_RESULT;
            end else begin
              error   <= 1'b0;
              ro_en   <= (ONE_HOT0 << sel_a) | (ONE_HOT0 << sel_b);
              busy    <= 1'b1;
              timer   <= '0;
              edges_a <= '0;
              edges_b <= '0;
              state   <= ST_SETTLE;
            end
          end
        end
        ST_SETTLE: begin
          if (timer == SETTLE_LAST) begin
            timer <= '0;
            state <= ST_COUNT;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        ST_COUNT: begin
          edges_a <= next_a;
          edges_b <= next_b;
          if (timer == WINDOW_LAST) begin
            count_a  <= next_a;
            count_b  <= next_b;
            response <= (next_a > next_b);
            done     <= 1'b1;
            busy     <= 1'b0;
            ro_en    <= '0;
            state    <= ST_RESULT;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        ST_RESULT: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ro_puf_challenge_ctrl.sv
// Bench for ro_puf_challenge_ctrl: expected outcomes are queued when a
// challenge is issued and compared when the controller pulses done.
module tb_ro_puf_challenge_ctrl;

  localparam int SETTLE_T = 4;
  localparam int WINDOW_T = 64;

  logic clk = 1'b0;
  logic rst, start, ro_a, ro_b;
  logic [7:0] sel_a, sel_b;

  logic [127:0] ro_en, ro_en4;
  logic [7:0]   mux_sel_a, mux_sel_b, mux_sel_a4, mux_sel_b4;
  logic         busy, done, response, error;
  logic         busy4, done4, response4, error4;
  logic [15:0]  count_a, count_b;
  logic [3:0]   count_a4, count_b4;

  ro_puf_challenge_ctrl #(.N_RO(128), .SEL_W(8), .CNT_W(16), .SETTLE(SETTLE_T), .WINDOW(WINDOW_T)) dut (
    .clk(clk), .rst(rst), .start(start), .sel_a(sel_a), .sel_b(sel_b),
    .ro_en(ro_en), .mux_sel_a(mux_sel_a), .mux_sel_b(mux_sel_b),
    .ro_a(ro_a), .ro_b(ro_b), .busy(busy), .done(done), .response(response),
    .error(error), .count_a(count_a), .count_b(count_b));

  ro_puf_challenge_ctrl #(.N_RO(128), .SEL_W(8), .CNT_W(4), .SETTLE(SETTLE_T), .WINDOW(WINDOW_T)) dut4 (
    .clk(clk), .rst(rst), .start(start), .sel_a(sel_a), .sel_b(sel_b),
    .ro_en(ro_en4), .mux_sel_a(mux_sel_a4), .mux_sel_b(mux_sel_b4),
    .ro_a(ro_a), .ro_b(ro_b), .busy(busy4), .done(done4), .response(response4),
    .error(error4), .count_a(count_a4), .count_b(count_b4));

  always #5 clk = ~clk;

  typedef struct {
    bit use4;
    int lat;
    bit err;
    bit resp;
    int a_lo, a_hi, b_lo, b_hi;
  } exp_t;

  exp_t sbq[$];
  int errors = 0;
  int checks = 0;

  // Oscillator models: square waves with a period in clock cycles (0 = stopped)
  int per_a = 0, per_b = 0, ph_a = -1, ph_b = -1;
  always @(posedge clk) begin
    #2;
    if (per_a > 0) begin ph_a = (ph_a + 1) % per_a; ro_a = (ph_a < per_a / 2); end
    else ro_a = 1'b0;
    if (per_b > 0) begin ph_b = (ph_b + 1) % per_b; ro_b = (ph_b < per_b / 2); end
    else ro_b = 1'b0;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic set_osc(input int pa, input int pb);
    per_a = pa; per_b = pb; ph_a = -1; ph_b = -1;
    repeat (3) @(negedge clk);
  endtask

  // Issue a challenge, queue its expected outcome, check the T+1 view.
  task automatic apply_start(input logic [7:0] sa, input logic [7:0] sb,
                             input int pa, input int pb, input bit use4);
    exp_t e;
    int ea, eb, tol, maxc;
    bit valid;
    logic [127:0] exp_en;
    ea = (pa > 0) ? WINDOW_T / pa : 0;
    eb = (pb > 0) ? WINDOW_T / pb : 0;
    maxc = use4 ? 15 : 65535;
    if (ea > maxc) ea = maxc;
    if (eb > maxc) eb = maxc;
    tol = use4 ? 0 : 1;
    valid = !(sa[7] || sb[7] || sa == sb);
    e.use4 = use4;
    exp_en = '0;
    if (valid) begin
      e.lat = SETTLE_T + WINDOW_T; e.err = 1'b0; e.resp = (ea > eb);
      e.a_lo = (ea > tol) ? ea - tol : 0; e.a_hi = ea + tol;
      e.b_lo = (eb > tol) ? eb - tol : 0; e.b_hi = eb + tol;
      exp_en[sa] = 1'b1; exp_en[sb] = 1'b1;
    end else begin
      e.lat = 0; e.err = 1'b1; e.resp = 1'b0;
      e.a_lo = 0; e.a_hi = 0; e.b_lo = 0; e.b_hi = 0;
    end
    @(negedge clk);
    sel_a = sa; sel_b = sb; start = 1'b1;
    sbq.push_back(e);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ((use4 ? ro_en4 : ro_en) !== exp_en) begin
      errors++;
      $display("FAIL ro_en_t1: got %h expected %h", use4 ? ro_en4 : ro_en, exp_en);
    end
    checks++;
    if ((use4 ? busy4 : busy) !== valid) begin
      errors++;
      $display("FAIL busy_t1: got %b expected %b", use4 ? busy4 : busy, valid);
    end
    checks++;
    if ((use4 ? mux_sel_a4 : mux_sel_a) !== sa || (use4 ? mux_sel_b4 : mux_sel_b) !== sb) begin
      errors++;
      $display("FAIL mux_sel_latch: got %0d/%0d expected %0d/%0d",
               use4 ? mux_sel_a4 : mux_sel_a, use4 ? mux_sel_b4 : mux_sel_b, sa, sb);
    end
  endtask

  // Wait (bounded) for done, pop the expectation and compare results.
  task automatic wait_done(input int pre);
    exp_t e;
    int n, ca, cb;
    bit r, er;
    e = sbq.pop_front();
    n = pre;
    while (!(e.use4 ? done4 : done) && n < e.lat + 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != e.lat) begin
      errors++;
      $display("FAIL done_latency: got %0d cycles after T+1, expected %0d", n, e.lat);
    end
    ca = e.use4 ? int'(count_a4) : int'(count_a);
    cb = e.use4 ? int'(count_b4) : int'(count_b);
    r  = e.use4 ? response4 : response;
    er = e.use4 ? error4 : error;
    checks++;
    if (er !== e.err) begin errors++; $display("FAIL error_flag: got %b expected %b", er, e.err); end
    checks++;
    if (r !== e.resp) begin errors++; $display("FAIL response: got %b expected %b", r, e.resp); end
    checks++;
    if (ca < e.a_lo || ca > e.a_hi) begin
      errors++; $display("FAIL count_a: got %0d expected %0d..%0d", ca, e.a_lo, e.a_hi);
    end
    checks++;
    if (cb < e.b_lo || cb > e.b_hi) begin
      errors++; $display("FAIL count_b: got %0d expected %0d..%0d", cb, e.b_lo, e.b_hi);
    end
    checks++;
    if ((e.use4 ? ro_en4 : ro_en) !== '0 || (e.use4 ? busy4 : busy) !== 1'b0) begin
      errors++; $display("FAIL idle_at_done: ro_en=%h busy=%b expected 0/0",
                         e.use4 ? ro_en4 : ro_en, e.use4 ? busy4 : busy);
    end
    @(negedge clk);
    checks++;
    if ((e.use4 ? done4 : done) !== 1'b0) begin
      errors++; $display("FAIL done_pulse_width: got done=1 expected 0");
    end
    checks++;
    if ((e.use4 ? response4 : response) !== e.resp) begin
      errors++; $display("FAIL response_hold: got %b expected %b", e.use4 ? response4 : response, e.resp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sel_a = '0; sel_b = '0; ro_a = 1'b0; ro_b = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (ro_en !== '0 || busy !== 1'b0 || done !== 1'b0 || count_a !== '0 || count_b !== '0
        || error !== 1'b0 || response !== 1'b0 || mux_sel_a !== '0 || mux_sel_b !== '0) begin
      errors++;
      $display("FAIL reset_values: ro_en=%h busy=%b done=%b ca=%0d cb=%0d err=%b resp=%b expected all 0",
               ro_en, busy, done, count_a, count_b, error, response);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_abort();
    int dones;
    set_osc(4, 8);
    @(negedge clk);
    sel_a = 8'd5; sel_b = 8'd100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b expected 1", busy); end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (ro_en !== '0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_immediate: ro_en=%h busy=%b expected 0/0", ro_en, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin errors++; $display("FAIL abort_no_done: got %0d done pulses expected 0", dones); end
    checks++;
    if (count_a !== '0 || count_b !== '0) begin
      errors++; $display("FAIL abort_counts: got %0d/%0d expected 0/0", count_a, count_b);
    end
  endtask

  task automatic test_a_faster();
    set_osc(4, 8);
    apply_start(8'd5, 8'd100, 4, 8, 1'b0);
    wait_done(0);
  endtask

  task automatic test_b_faster();
    set_osc(16, 4);
    apply_start(8'd0, 8'd127, 16, 4, 1'b0);
    wait_done(0);
  endtask

  task automatic test_tie();
    set_osc(8, 8);
    apply_start(8'd20, 8'd21, 8, 8, 1'b0);
    wait_done(0);
    checks++;
    if (count_a !== count_b) begin
      errors++; $display("FAIL tie_equal: got %0d vs %0d expected equal", count_a, count_b);
    end
  endtask

  task automatic test_invalid();
    set_osc(4, 8);
    apply_start(8'd9, 8'd9, 4, 8, 1'b0);
    wait_done(0);
    apply_start(8'h80, 8'd3, 4, 8, 1'b0);
    wait_done(0);
  endtask

  task automatic test_saturation_ignore();
    int dones;
    set_osc(4, 0);
    apply_start(8'd3, 8'd50, 4, 0, 1'b1);
    repeat (20) @(negedge clk);
    sel_a = 8'd7; sel_b = 8'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (mux_sel_a4 !== 8'd3 || mux_sel_b4 !== 8'd50 || busy4 !== 1'b1) begin
      errors++; $display("FAIL ignore_start: mux=%0d/%0d busy=%b expected 3/50/1",
                         mux_sel_a4, mux_sel_b4, busy4);
    end
    wait_done(21);
    dones = 0;
    for (int i = 0; i < 90; i++) begin
      @(negedge clk);
      if (done4 === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin errors++; $display("FAIL single_done: got %0d extra done pulses expected 0", dones); end
  endtask

  initial begin
    test_reset();
    test_abort();
    test_a_faster();
    test_b_faster();
    test_tie();
    test_invalid();
    test_saturation_ignore();
    checks++;
    if (sbq.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left expected 0", sbq.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
